siaminer_cmd_parser: RTL and testbench

Packet-level command parser and response framer between the UART byte receiver/transmitter and `siacore` inside `uart2core`. It assembles host packets (`0xAA`, cmd, len, payload) into a 640-bit work and 32-bit target for the core, and echoes loop-test payloads. It frames nonce results from the core into response packets (`0x55`, cmd, len, payload) for the UART transmitter.

---
 rtl/siaminer_cmd_parser.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_siaminer_cmd_parser.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siaminer_cmd_parser.sv
// Host packet parser and response framer between the UART and siacore.
// RX: 0xAA, cmd, len, payload -> work/target or a loop-test echo.
// TX: 0x55, cmd, len, payload for nonce results (first) and loop echoes.
module siaminer_cmd_parser #(
    parameter int unsigned TIMEOUT  = 100000,
    parameter int unsigned LOOP_MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         new_rx_data,
    input  logic         tx_busy,
    output logic [7:0]   tx_data,
    output logic         new_tx_data,
    output logic [639:0] work,
    output logic [31:0]  target,
    output logic         work_valid,
    input  logic [31:0]  nonce,
    input  logic         nonce_valid,
    output logic         rx_last_byte,
    output logic         tx_last_byte,
    output logic         err
);
    localparam int unsigned EchoW = LOOP_MAX * 8;
    localparam int unsigned PayW  = (EchoW > 32) ? EchoW : 32;
    localparam int unsigned ToW   = $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);
    localparam logic [7:0] WorkLen = 8'd84;
    localparam logic [7:0] LoopMax = 8'(LOOP_MAX);
    localparam logic [7:0] CmdWork = 8'd0;
    localparam logic [7:0] CmdLoop = 8'd1;

    typedef enum logic [2:0] {RIdle, RCmd, RLen, RData, RDiscard} rx_state_e;
    typedef enum logic [2:0] {TIdle, THdr, TCmd, TLen, TData} tx_state_e;

    rx_state_e            rx_state_q, rx_state_d;
    logic [7:0]           cmd_q, cmd_d, len_q, len_d, cnt_q, cnt_d;
    logic [671:0]         shift_q, shift_d;
    logic [EchoW-1:0]     stage_q, stage_d, echo_q, echo_d;
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;
    logic [639:0]         work_q, work_d;
    logic [31:0]          target_q, target_d;
    logic                 work_valid_q, work_valid_d;
    logic [7:0]           loop_len_q, loop_len_d;
    logic                 loop_pending_q, loop_pending_d;
    logic [31:0]          nonce_q, nonce_d;
    logic                 nonce_pending_q, nonce_pending_d;
    logic                 err_q, err_d;

    tx_state_e            tx_state_q, tx_state_d;
    logic                 tx_sel_q, tx_sel_d;  // 0: nonce response, 1: loop echo
    logic [7:0]           tx_len_q, tx_len_d, tx_idx_q, tx_idx_d;
    logic [PayW-1:0]      tx_pay_q, tx_pay_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 new_tx_q, new_tx_d, tx_last_q, tx_last_d;

    logic last_cnt, loop_done, rx_err, loop_busy, loop_drop, nonce_drop;
    logic can_send, tx_go, nonce_clr, loop_clr;

    assign last_cnt    = (cnt_q == len_q - 8'd1);
    assign can_send    = !tx_busy && !new_tx_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign tx_last_byte = tx_last_q;
    assign work        = work_q;
    assign target      = target_q;
    assign work_valid  = work_valid_q;
    assign err         = err_q;

    // RX packet FSM with inter-byte timeout
    always_comb begin
        rx_state_d   = rx_state_q;
        cmd_d        = cmd_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        stage_d      = stage_q;
        to_cnt_d     = '0;
        work_d       = work_q;
        target_d     = target_q;
        work_valid_d = 1'b0;
        loop_done    = 1'b0;
        rx_err       = 1'b0;
        if (rx_state_q != RIdle && !new_rx_data) begin
            if (to_cnt_q == ToLast) begin
                rx_state_d = RIdle;
                rx_err     = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
        if (new_rx_data) begin
            case (rx_state_q)
                RIdle: if (rx_data == 8'hAA) rx_state_d = RCmd;
                RCmd: begin
                    cmd_d      = rx_data;
                    rx_state_d = RLen;
                end
                RLen: begin
                    len_d = rx_data;
                    cnt_d = 8'd0;
                    if (cmd_q == CmdWork && rx_data == WorkLen) begin
                        rx_state_d = RData;
                    end else if (cmd_q == CmdLoop && rx_data != 8'd0 && rx_data <= LoopMax) begin
                        rx_state_d = RData;
                    end else if (cmd_q == CmdLoop && rx_data == 8'd0) begin
                        loop_done  = 1'b1;
                        rx_state_d = RIdle;
                    end else begin
                        rx_err     = 1'b1;
                        rx_state_d = (rx_data != 8'd0) ? RDiscard : RIdle;
                    end
                end
                RData: begin
                    shift_d = {rx_data, shift_q[671:8]};
                    for (int unsigned i = 0; i < LOOP_MAX; i++) begin
                        if (cmd_q == CmdLoop && cnt_q == 8'(i)) stage_d[i*8 +: 8] = rx_data;
                    end
                    if (last_cnt) begin
                        rx_state_d = RIdle;
                        if (cmd_q == CmdWork) begin
                            work_d       = shift_d[639:0];
                            target_d     = shift_d[671:640];
                            work_valid_d = 1'b1;
                        end else begin
                            loop_done = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                RDiscard: begin
                    if (last_cnt) rx_state_d = RIdle;
                    else cnt_d = cnt_q + 8'd1;
                end
                default: rx_state_d = RIdle;
            endcase
        end
    end

    // Next accepted byte completes the current packet
    always_comb begin
        rx_last_byte = 1'b0;
        case (rx_state_q)
            RLen:            rx_last_byte = (rx_data == 8'd0);
            RData, RDiscard: rx_last_byte = last_cnt;
            default:         rx_last_byte = 1'b0;
        endcase
    end

    // Pending slots for the loop echo and the nonce; a slot freed this cycle can refill
    always_comb begin
        loop_busy       = loop_pending_q & ~loop_clr;
        loop_pending_d  = loop_busy;
        loop_len_d      = loop_len_q;
        echo_d          = echo_q;
        loop_drop       = 1'b0;
        if (loop_done) begin
            if (loop_busy) begin
                loop_drop = 1'b1;
            end else begin
                loop_pending_d = 1'b1;
                loop_len_d     = len_d;
                echo_d         = stage_d;
            end
        end
        nonce_pending_d = nonce_pending_q & ~nonce_clr;
        nonce_d         = nonce_q;
        nonce_drop      = 1'b0;
        if (nonce_valid) begin
            if (nonce_pending_d) begin
                nonce_drop = 1'b1;
            end else begin
                nonce_d         = nonce;
                nonce_pending_d = 1'b1;
            end
        end
        err_d = rx_err | loop_drop | nonce_drop;
    end

    // TX response FSM; the header goes out straight from idle so a fresh nonce has 1-cycle latency
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sel_d   = tx_sel_q;
        tx_len_d   = tx_len_q;
        tx_idx_d   = tx_idx_q;
        tx_pay_d   = tx_pay_q;
        tx_data_d  = tx_data_q;
        new_tx_d   = 1'b0;
        tx_last_d  = 1'b0;
        tx_go      = 1'b0;
        case (tx_state_q)
            TIdle: begin
                if (nonce_pending_q || nonce_valid) begin
                    tx_go    = 1'b1;
                    tx_sel_d = 1'b0;
                    tx_len_d = 8'd4;
                    tx_pay_d = PayW'(nonce_pending_q ? nonce_q : nonce);
                end else if (loop_pending_q) begin
                    tx_go    = 1'b1;
                    tx_sel_d = 1'b1;
                    tx_len_d = loop_len_q;
                    tx_pay_d = PayW'(echo_q);
                end
                if (tx_go) begin
                    if (can_send) begin
                        tx_data_d  = 8'h55;
                        new_tx_d   = 1'b1;
                        tx_state_d = TCmd;
                    end else begin
                        tx_state_d = THdr;
                    end
                end
            end
            THdr: if (can_send) begin
                tx_data_d  = 8'h55;
                new_tx_d   = 1'b1;
                tx_state_d = TCmd;
            end
            TCmd: if (can_send) begin
                tx_data_d  = {7'd0, tx_sel_q};
                new_tx_d   = 1'b1;
                tx_state_d = TLen;
            end
            TLen: if (can_send) begin
                tx_data_d = tx_len_q;
                new_tx_d  = 1'b1;
                tx_idx_d  = 8'd0;
                if (tx_len_q == 8'd0) begin
                    tx_last_d  = 1'b1;
                    tx_state_d = TIdle;
                end else begin
                    tx_state_d = TData;
                end
            end
            TData: if (can_send) begin
                tx_data_d = tx_pay_q[7:0];
                tx_pay_d  = tx_pay_q >> 8;
                new_tx_d  = 1'b1;
                if (tx_idx_q == tx_len_q - 8'd1) begin
                    tx_last_d  = 1'b1;
                    tx_state_d = TIdle;
                end else begin
                    tx_idx_d = tx_idx_q + 8'd1;
                end
            end
            default: tx_state_d = TIdle;
        endcase
        nonce_clr = tx_last_d && !tx_sel_q;
        loop_clr  = tx_last_d && tx_sel_q;
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q      <= RIdle;
            cmd_q           <= '0;
            len_q           <= '0;
            cnt_q           <= '0;
            shift_q         <= '0;
            stage_q         <= '0;
            to_cnt_q        <= '0;
            work_q          <= '0;
            target_q        <= '0;
            work_valid_q    <= 1'b0;
            echo_q          <= '0;
            loop_len_q      <= '0;
            loop_pending_q  <= 1'b0;
            nonce_q         <= '0;
            nonce_pending_q <= 1'b0;
            err_q           <= 1'b0;
            tx_state_q      <= TIdle;
            tx_sel_q        <= 1'b0;
            tx_len_q        <= '0;
            tx_idx_q        <= '0;
            tx_pay_q        <= '0;
            tx_data_q       <= '0;
            new_tx_q        <= 1'b0;
            tx_last_q       <= 1'b0;
        end else begin
            rx_state_q      <= rx_state_d;
            cmd_q           <= cmd_d;
            len_q           <= len_d;
            cnt_q           <= cnt_d;
            shift_q         <= shift_d;
            stage_q         <= stage_d;
            to_cnt_q        <= to_cnt_d;
            work_q          <= work_d;
            target_q        <= target_d;
            work_valid_q    <= work_valid_d;
            echo_q          <= echo_d;
            loop_len_q      <= loop_len_d;
            loop_pending_q  <= loop_pending_d;
            nonce_q         <= nonce_d;
            nonce_pending_q <= nonce_pending_d;
            err_q           <= err_d;
            tx_state_q      <= tx_state_d;
            tx_sel_q        <= tx_sel_d;
            tx_len_q        <= tx_len_d;
            tx_idx_q        <= tx_idx_d;
            tx_pay_q        <= tx_pay_d;
            tx_data_q       <= tx_data_d;
            new_tx_q        <= new_tx_d;
            tx_last_q       <= tx_last_d;
        end
    end
endmodule

// File: tb/tb_siaminer_cmd_parser.sv
// Directed testbench for siaminer_cmd_parser with a simple UART busy model.
module tb_siaminer_cmd_parser;
    localparam int unsigned TO = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = 8'd0;
    logic         new_rx_data = 1'b0;
    logic         tx_busy;
    logic [7:0]   tx_data;
    logic         new_tx_data;
    logic [639:0] work;
    logic [31:0]  target;
    logic         work_valid;
    logic [31:0]  nonce = 32'd0;
    logic         nonce_valid = 1'b0;
    logic         rx_last_byte;
    logic         tx_last_byte;
    logic         err;

    int checks = 0;
    int errors = 0;
    int wv_cnt = 0;
    int err_cnt = 0;
    int busy_len = 2;
    int busy_cnt;
    logic last_rx;
    logic [7:0] txq[$];
    logic       txl[$];

    always #5 clk = ~clk;

    siaminer_cmd_parser #(.TIMEOUT(TO), .LOOP_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data), .work(work),
        .target(target), .work_valid(work_valid), .nonce(nonce), .nonce_valid(nonce_valid),
        .rx_last_byte(rx_last_byte), .tx_last_byte(tx_last_byte), .err(err)
    );

    // UART transmitter model: busy for busy_len cycles after each strobe
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (!rst_n) busy_cnt <= 0;
        else if (new_tx_data) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Output monitor
    always @(negedge clk) begin
        if (new_tx_data) begin
            txq.push_back(tx_data);
            txl.push_back(tx_last_byte);
        end
        if (work_valid) wv_cnt++;
        if (err) err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        new_rx_data = 1'b1;
        #1 last_rx = rx_last_byte;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic clear_counts();
        @(negedge clk);
        #2;
        wv_cnt = 0;
        err_cnt = 0;
        txq.delete();
        txl.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (tx_data !== 8'd0) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        checks++; if (new_tx_data !== 1'b0) begin errors++; $display("FAIL rst_new_tx got %b want 0", new_tx_data); end
        checks++; if (work !== 640'd0) begin errors++; $display("FAIL rst_work got %h want 0", work[31:0]); end
        checks++; if (target !== 32'd0) begin errors++; $display("FAIL rst_target got %h want 0", target); end
        checks++; if (work_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b want 00", work_valid, err); end
        checks++; if (rx_last_byte !== 1'b0 || tx_last_byte !== 1'b0) begin errors++; $display("FAIL rst_last got %b%b want 00", rx_last_byte, tx_last_byte); end
        rst_n = 1'b1;
        clear_counts();
    endtask

    task automatic test_work();
        clear_counts();
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h54);
        for (int i = 0; i < 84; i++) begin
            send_byte(8'(i));
            if (i == 82) begin
                checks++; if (last_rx !== 1'b0) begin errors++; $display("FAIL work_rxlast_early got %b want 0", last_rx); end
            end
        end
        checks++; if (last_rx !== 1'b1) begin errors++; $display("FAIL work_rxlast got %b want 1", last_rx); end
        #1;
        checks++; if (wv_cnt != 1) begin errors++; $display("FAIL work_valid_timing got %0d want 1", wv_cnt); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (wv_cnt != 1) begin errors++; $display("FAIL work_valid_count got %0d want 1", wv_cnt); end
        checks++; if (work[7:0] !== 8'h00) begin errors++; $display("FAIL work_lo got %h want 00", work[7:0]); end
        checks++; if (work[639:632] !== 8'h4F) begin errors++; $display("FAIL work_hi got %h want 4f", work[639:632]); end
        checks++; if (work[15:8] !== 8'h01) begin errors++; $display("FAIL work_b1 got %h want 01", work[15:8]); end
        checks++; if (target !== 32'h53525150) begin errors++; $display("FAIL work_target got %h want 53525150", target); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL work_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_loop();
        logic [7:0] exp_b [6] = '{8'h55, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33};
        logic [7:0] exp_e [3] = '{8'h55, 8'h01, 8'h00};
        int n;
        clear_counts();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        n = 0;
        while (txq.size() < 6 && n < 300) begin @(negedge clk); #1; n++; end
        checks++; if (txq.size() != 6) begin errors++; $display("FAIL loop_count got %0d want 6", txq.size()); end
        for (int i = 0; i < 6 && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_b[i] || txl[i] !== (i == 5)) begin
                errors++; $display("FAIL loop_byte%0d got %h/%b want %h/%b", i, txq[i], txl[i], exp_b[i], i == 5);
            end
        end
        clear_counts();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00);
        checks++; if (last_rx !== 1'b1) begin errors++; $display("FAIL loop0_rxlast got %b want 1", last_rx); end
        n = 0;
        while (txq.size() < 3 && n < 300) begin @(negedge clk); #1; n++; end
        repeat (20) @(negedge clk);
        #1;
        checks++; if (txq.size() != 3) begin errors++; $display("FAIL loop0_count got %0d want 3", txq.size()); end
        for (int i = 0; i < 3 && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_e[i] || txl[i] !== (i == 2)) begin
                errors++; $display("FAIL loop0_byte%0d got %h/%b want %h/%b", i, txq[i], txl[i], exp_e[i], i == 2);
            end
        end
    endtask

    task automatic test_bad_len();
        clear_counts();
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'hAA);
        checks++; if (last_rx !== 1'b1) begin errors++; $display("FAIL bad_rxlast got %b want 1", last_rx); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL bad_err got %0d want 1", err_cnt); end
        checks++; if (wv_cnt != 0) begin errors++; $display("FAIL bad_wv got %0d want 0", wv_cnt); end
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h54);
        for (int i = 0; i < 84; i++) send_byte(8'(8'h80 + i));
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wv_cnt != 1) begin errors++; $display("FAIL bad_next_wv got %0d want 1", wv_cnt); end
        checks++; if (work[7:0] !== 8'h80 || target !== 32'hD3D2D1D0) begin
            errors++; $display("FAIL bad_next_data got %h/%h want 80/d3d2d1d0", work[7:0], target);
        end
    endtask

    task automatic test_nonce();
        logic [7:0] exp_b [7] = '{8'h55, 8'h00, 8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int n;
        busy_len = 3;
        clear_counts();
        @(negedge clk);
        nonce = 32'hDEADBEEF;
        nonce_valid = 1'b1;
        @(negedge clk);
        nonce_valid = 1'b0;
        #1;
        checks++; if (new_tx_data !== 1'b1 || tx_data !== 8'h55) begin
            errors++; $display("FAIL nonce_latency got %b/%h want 1/55", new_tx_data, tx_data);
        end
        n = 0;
        while (txq.size() < 4 && n < 300) begin @(negedge clk); #1; n++; end
        nonce = 32'h12345678;
        nonce_valid = 1'b1;
        @(negedge clk);
        nonce_valid = 1'b0;
        n = 0;
        while (txq.size() < 7 && n < 300) begin @(negedge clk); #1; n++; end
        repeat (60) @(negedge clk);
        #1;
        checks++; if (txq.size() != 7) begin errors++; $display("FAIL nonce_count got %0d want 7", txq.size()); end
        for (int i = 0; i < 7 && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_b[i] || txl[i] !== (i == 6)) begin
                errors++; $display("FAIL nonce_byte%0d got %h/%b want %h/%b", i, txq[i], txl[i], exp_b[i], i == 6);
            end
        end
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL nonce_drop_err got %0d want 1", err_cnt); end
        busy_len = 2;
    endtask

    task automatic test_timeout();
        clear_counts();
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h54);
        for (int i = 0; i < 10; i++) send_byte(8'hEE);
        repeat (TO - 2) @(negedge clk);
        #1;
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL to_early got %0d want 0", err_cnt); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL to_err got %0d want 1", err_cnt); end
        checks++; if (wv_cnt != 0 || target !== 32'hD3D2D1D0) begin
            errors++; $display("FAIL to_no_update got %0d/%h want 0/d3d2d1d0", wv_cnt, target);
        end
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h54);
        for (int i = 0; i < 84; i++) send_byte(8'(i));
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wv_cnt != 1 || target !== 32'h53525150) begin
            errors++; $display("FAIL to_recover got %0d/%h want 1/53525150", wv_cnt, target);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [12] = '{8'h55, 8'h00, 8'h04, 8'h04, 8'h03, 8'h02, 8'h01,
                                   8'h55, 8'h01, 8'h02, 8'h77, 8'h88};
        int n;
        clear_counts();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h77);
        @(negedge clk);
        rx_data = 8'h88;
        new_rx_data = 1'b1;
        nonce = 32'h01020304;
        nonce_valid = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        nonce_valid = 1'b0;
        n = 0;
        while (txq.size() < 12 && n < 400) begin @(negedge clk); #1; n++; end
        checks++; if (txq.size() != 12) begin errors++; $display("FAIL b2b_count got %0d want 12", txq.size()); end
        for (int i = 0; i < 12 && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_b[i] || txl[i] !== (i == 6 || i == 11)) begin
                errors++; $display("FAIL b2b_byte%0d got %h/%b want %h", i, txq[i], txl[i], exp_b[i]);
            end
        end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL b2b_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        int sz;
        clear_counts();
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h54);
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (work !== 640'd0 || target !== 32'd0) begin
            errors++; $display("FAIL rstmid_work got %h/%h want 0/0", work[31:0], target);
        end
        rst_n = 1'b1;
        for (int i = 20; i < 84; i++) send_byte(8'(i));
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wv_cnt != 0 || err_cnt != 0) begin
            errors++; $display("FAIL rstmid_abandon got %0d/%0d want 0/0", wv_cnt, err_cnt);
        end
        clear_counts();
        @(negedge clk);
        nonce = 32'hCAFEF00D;
        nonce_valid = 1'b1;
        @(negedge clk);
        nonce_valid = 1'b0;
        n = 0;
        while (txq.size() < 3 && n < 300) begin @(negedge clk); #1; n++; end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (new_tx_data !== 1'b0 || tx_data !== 8'd0 || tx_last_byte !== 1'b0) begin
            errors++; $display("FAIL rstmid_tx got %b/%h/%b want 0/00/0", new_tx_data, tx_data, tx_last_byte);
        end
        sz = txq.size();
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        checks++; if (txq.size() != sz || sz < 3) begin
            errors++; $display("FAIL rstmid_trailing got %0d want %0d (>=3)", txq.size(), sz);
        end
    endtask

    initial begin
        test_reset();
        test_work();
        test_loop();
        test_bad_len();
        test_nonce();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
